// File: rtl/lv1a_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lv1a_pattern_gen
//  Description : L1A trigger pattern generator. Emits 1-cycle L1A pulses at a
//                programmable gap in continuous, burst-of-N or single-shot
//                mode and fans them out to NCH masked channels.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        system clock, posedge
//    rst_n      asynchronous active-low reset
//    in_live    live gate (ANDed with in_ena)
//    in_ena     enable gate
//    ena_gen    run control level; rising edge starts, low aborts
//    mode       0=continuous 1=burst 2=single 3=continuous
//    gap        cycles between triggers (0 treated as 1)
//    burst_len  trigger count for burst mode
//    chan_mask  per-channel output enable
//    out_lv1a   registered trigger pulses per channel
//    busy       run in progress (RUN or PAUSE)
//    done       burst/single run completed
//    trig_cnt   triggers issued since last start, saturating
// ============================================================================
module lv1a_pattern_gen #(
  parameter int GAP_W = 16,
  parameter int CNT_W = 16,
  parameter int NCH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_live,
  input  logic             in_ena,
  input  logic             ena_gen,
  input  logic [1:0]       mode,
  input  logic [GAP_W-1:0] gap,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [NCH-1:0]   chan_mask,
  output logic [NCH-1:0]   out_lv1a,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] trig_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] MODE_BURST  = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  logic [1:0]       state, state_n;
  logic             ena_q;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             pend, pend_n;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       mode_q;
  logic [GAP_W-1:0] gap_q;
  logic [CNT_W-1:0] len_q;
  logic [NCH-1:0]   mask_q;

  logic             start, gate, load, fire;
  logic [1:0]       mode_sel;
  logic [CNT_W-1:0] len_sel;
  logic [NCH-1:0]   mask_sel;

  assign start = ena_gen & ~ena_q;
  assign gate  = in_live & in_ena;

  // On a start edge the new configuration is being latched in the same edge,
  // so completion and masking must look at the live inputs rather than the
  // stale copies.
  assign mode_sel = load ? mode      : mode_q;
  assign len_sel  = load ? burst_len : len_q;
  assign mask_sel = load ? chan_mask : mask_q;

  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    pend_n    = pend;
    cnt_n     = trig_cnt;
    load      = 1'b0;
    fire      = 1'b0;

    if (!ena_gen) begin
      // Abort wins over everything, including a due trigger.
      state_n = ST_IDLE;
    end else if (start && (state == ST_IDLE || state == ST_DONE)) begin
      load      = 1'b1;
      cnt_n     = '0;
      gap_cnt_n = '0;
      pend_n    = 1'b0;
      if (mode == MODE_BURST && burst_len == '0) begin
        state_n = ST_DONE;
      end else if (gate) begin
        fire    = 1'b1;
        state_n = ST_RUN;
      end else begin
        pend_n  = 1'b1;
        state_n = ST_PAUSE;
      end
    end else if (state == ST_RUN || state == ST_PAUSE) begin
      if (!gate) begin
        // Gap count is frozen while gated, so gated cycles simply stretch
        // the interval by their own number.
        state_n = ST_PAUSE;
      end else begin
        state_n = ST_RUN;
        if (pend) begin
          fire   = 1'b1;
          pend_n = 1'b0;
        end else if (gap_cnt == gap_q - GAP_W'(1)) begin
          fire      = 1'b1;
          gap_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
    end

    if (fire) begin
      if (cnt_n != '1) begin
        cnt_n = cnt_n + CNT_W'(1);
      end
      if (mode_sel == MODE_SINGLE || (mode_sel == MODE_BURST && cnt_n == len_sel)) begin
        state_n = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ena_q    <= 1'b0;
      gap_cnt  <= '0;
      pend     <= 1'b0;
      trig_cnt <= '0;
      out_lv1a <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mode_q   <= '0;
      gap_q    <= GAP_W'(1);
      len_q    <= '0;
      mask_q   <= '0;
    end else begin
      state    <= state_n;
      ena_q    <= ena_gen;
      gap_cnt  <= gap_cnt_n;
      pend     <= pend_n;
      trig_cnt <= cnt_n;
      out_lv1a <= fire ? mask_sel : '0;
      busy     <= (state_n == ST_RUN) || (state_n == ST_PAUSE);
      done     <= (state_n == ST_DONE);
      if (load) begin
        mode_q <= mode;
        gap_q  <= (gap == '0) ? GAP_W'(1) : gap;
        len_q  <= burst_len;
        mask_q <= chan_mask;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lv1a_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lv1a_pattern_gen
//  Description : Self-checking bench for lv1a_pattern_gen against a
//                countdown-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lv1a_pattern_gen;

  localparam int GAP_W = 16;
  localparam int CNT_W = 6;
  localparam int NCH   = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_live = 1'b0;
  logic             in_ena = 1'b0;
  logic             ena_gen = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [GAP_W-1:0] gap = '0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [NCH-1:0]   chan_mask = '0;
  logic [NCH-1:0]   out_lv1a;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] trig_cnt;

  lv1a_pattern_gen #(.GAP_W(GAP_W), .CNT_W(CNT_W), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_live(in_live), .in_ena(in_ena),
    .ena_gen(ena_gen), .mode(mode), .gap(gap), .burst_len(burst_len),
    .chan_mask(chan_mask), .out_lv1a(out_lv1a), .busy(busy), .done(done),
    .trig_cnt(trig_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
  endtask

  // Reference model: a run is "active" while triggers may still come; the
  // next trigger is due after m_wait more gated-open edges.
  bit  m_prev, m_active, m_finished;
  int  m_mode, m_gap, m_len, m_mask, m_issued, m_wait;
  int  exp_out;

  task automatic model_reset();
    m_prev = 0; m_active = 0; m_finished = 0; m_issued = 0; m_wait = 0;
    exp_out = 0;
  endtask

  task automatic model_step();
    bit rise, g;
    rise = ena_gen && !m_prev;
    g    = in_live && in_ena;
    m_prev  = ena_gen;
    exp_out = 0;
    if (!ena_gen) begin
      m_active = 0; m_finished = 0;
    end else if (rise && !m_active) begin
      m_mode = int'(mode); m_gap = (gap == 0) ? 1 : int'(gap);
      m_len = int'(burst_len); m_mask = int'(chan_mask);
      m_issued = 0; m_finished = 0; m_wait = 0;
      if (m_mode == 1 && m_len == 0) m_finished = 1;
      else m_active = 1;
    end
    if (m_active && g) begin
      if (m_wait == 0) begin
        exp_out = m_mask;
        m_wait  = m_gap - 1;
        if (m_issued < CMAX) m_issued++;
        if (m_mode == 2 || (m_mode == 1 && m_issued == m_len)) begin
          m_active = 0; m_finished = 1;
        end
      end else begin
        m_wait--;
      end
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".out"},  32'(out_lv1a), 32'(exp_out));
    check({where, ".busy"}, 32'(busy),     32'(m_active));
    check({where, ".done"}, 32'(done),     32'(m_finished));
    check({where, ".cnt"},  32'(trig_cnt), 32'(m_issued));
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    model_step();
    #1;
    compare_all(where);
  endtask

  task automatic run(input string where, input int n);
    for (int i = 0; i < n; i++) cycle(where);
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("arst");
    #2;
    rst_n = 1'b1;
  endtask

  task automatic setup(input logic [1:0] md, input int gp, input int ln, input logic [3:0] mk);
    mode = md; gap = GAP_W'(gp); burst_len = CNT_W'(ln); chan_mask = mk;
  endtask

  int pulses;

  initial begin
    model_reset();
    #1;
    compare_all("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    in_live = 1'b1; in_ena = 1'b1;

    // continuous, gap 4
    setup(2'd0, 4, 0, 4'hF);
    ena_gen = 1'b1;
    run("cont4", 20);
    ena_gen = 1'b0; run("abort", 2);

    // burst of 3, gap 2
    setup(2'd1, 2, 3, 4'hF);
    ena_gen = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle("burst3");
      if (out_lv1a != 0) pulses++;
    end
    check("burst3.pulses", 32'(pulses), 32'd3);
    ena_gen = 1'b0; run("abort", 2);

    // continuous gap 5 with 3 gated cycles mid-gap
    setup(2'd0, 5, 0, 4'hF);
    ena_gen = 1'b1;
    run("gap5", 7);
    in_live = 1'b0; run("gated", 3);
    in_live = 1'b1; run("gap5b", 10);
    ena_gen = 1'b0; run("abort", 2);

    // single shot started while gated
    setup(2'd2, 3, 0, 4'hA);
    in_ena = 1'b0; ena_gen = 1'b1;
    run("single_g", 3);
    in_ena = 1'b1; run("single", 4);
    ena_gen = 1'b0; run("abort", 2);

    // gap 0 with partial mask; long enough to saturate trig_cnt
    setup(2'd0, 0, 0, 4'b0101);
    ena_gen = 1'b1;
    run("gap0", CMAX + 6);
    ena_gen = 1'b0; run("abort", 2);

    // burst length 0
    setup(2'd1, 3, 0, 4'hF);
    ena_gen = 1'b1;
    run("len0", 4);
    ena_gen = 1'b0; run("abort", 2);

    // abort mid-burst, then restart and reset mid-run
    setup(2'd1, 3, 9, 4'hF);
    ena_gen = 1'b1; run("burst9", 5);
    ena_gen = 1'b0; run("midabort", 3);
    ena_gen = 1'b1; run("restart", 5);
    async_reset();
    run("postrst", 4);
    ena_gen = 1'b0; run("low", 2);

    // randomized phase: live config changes, random gating and enable toggles
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) ena_gen = ~ena_gen;
      in_live = ($urandom_range(0, 99) < 85);
      in_ena  = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 99) < 30)
        setup(2'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom_range(0, 5), 4'($urandom));
      cycle("rand");
      if (i == 1500) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
